// File: rtl/clint_trap_ctrl.sv
// ---------------------------------------------------------------------------
// clint_trap_ctrl
//
// Core-local trap sequencer. Takes ecall/ebreak, mret and the machine timer
// interrupt, holds the pipeline, performs the machine-CSR updates one write
// per cycle through the CSR file's clint write port, and then issues a
// one-cycle fetch redirect to the trap vector or to mepc.
//
// Optional feature macro: CLINT_VECTORED_EN
//   defined     : vectored mode (mtvec[1:0]==2'b01) sends interrupts to
//                 base + 4*cause[30:0]; synchronous traps use the base.
//   not defined : every trap goes to {mtvec[31:2],2'b00}.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   inst_addr_i           PC of the instruction in EX
//   ecall_i/ebreak_i/mret_i  decoded system instruction valid in EX
//   jump_i, jump_addr_i   EX is redirecting; target used as mepc for irqs
//   hold_i                EX busy with a multi-cycle op; irqs not accepted
//   timer_irq_i           level-sensitive machine timer interrupt
//   global_int_en_i       mstatus.MIE
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i  current CSR values
//   csr_wb_we_i           WB owns the CSR write port this cycle
//   csr_we_o/csr_waddr_o/csr_wdata_o      clint CSR write port
//   hold_flag_o           stall request for IF/ID/EX (combinational)
//   int_assert_o          one-cycle fetch redirect
//   int_addr_o            redirect target, valid with int_assert_o
//
// Handshake: a CSR write is committed in exactly the cycles where
// csr_we_o=1. A write state whose cycle coincides with csr_wb_we_i=1 is
// not committed; the state is kept and the write retried next cycle.
//
// The FSM state is visible as state_q for debug/assertion binding.
// ---------------------------------------------------------------------------
module clint_trap_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_addr_i,
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        mret_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   input  logic        timer_irq_i,
   input  logic        global_int_en_i,
   input  logic [31:0] csr_mtvec_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mstatus_i,
   input  logic        csr_wb_we_i,
   output logic        csr_we_o,
   output logic [31:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic        hold_flag_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o
);

   localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;
   localparam logic [31:0] CAUSE_MTIMER = 32'h8000_0007;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WR_MEPC     = 3'd1,
      S_WR_MSTATUS  = 3'd2,
      S_WR_MCAUSE   = 3'd3,
      S_ASSERT      = 3'd4,
      S_RET_MSTATUS = 3'd5,
      S_RET_ASSERT  = 3'd6
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] mepc_val_q, mepc_val_d;
   logic [31:0] cause_q, cause_d;

   logic        sys_trap;
   logic        irq_take;
   logic        accept;

   logic        we_raw;
   logic [31:0] waddr_raw;
   logic [31:0] wdata_raw;
   logic        assert_raw;
   logic [31:0] iaddr_raw;

   logic [31:0] mtvec_base;
   logic [31:0] trap_vector;

   // Priority: ecall/ebreak, then mret, then the timer interrupt. The irq is
   // only taken when no system instruction occupies EX.
   assign sys_trap = ecall_i | ebreak_i;
   assign irq_take = timer_irq_i & global_int_en_i & ~hold_i & ~sys_trap & ~mret_i;
   assign accept   = (state_q == S_IDLE) & (sys_trap | mret_i | irq_take);

   assign mtvec_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
   // Only asynchronous causes (bit 31 set) are vectored.
   assign trap_vector = ((csr_mtvec_i[1:0] == 2'b01) && cause_q[31]) ?
                        (mtvec_base + {cause_q[29:0], 2'b00}) : mtvec_base;
`else
   logic unused_mode;
   assign unused_mode = ^csr_mtvec_i[1:0];
   assign trap_vector = mtvec_base;
`endif

   // Next-state and latch logic.
   always_comb begin
      state_d    = state_q;
      mepc_val_d = mepc_val_q;
      cause_d    = cause_q;
      case (state_q)
         S_IDLE: begin
            if (sys_trap) begin
               mepc_val_d = inst_addr_i;
               cause_d    = ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
               state_d    = S_WR_MEPC;
            end else if (mret_i) begin
               state_d = S_RET_MSTATUS;
            end else if (irq_take) begin
               // A jump in EX is already resolved; returning to its target
               // keeps the branch effect.
               mepc_val_d = jump_i ? jump_addr_i : inst_addr_i;
               cause_d    = CAUSE_MTIMER;
               state_d    = S_WR_MEPC;
            end
         end
         S_WR_MEPC: begin
            if (!csr_wb_we_i) state_d = S_WR_MSTATUS;
         end
         S_WR_MSTATUS: begin
            if (!csr_wb_we_i) state_d = S_WR_MCAUSE;
         end
         S_WR_MCAUSE: begin
            if (!csr_wb_we_i) state_d = S_ASSERT;
         end
         S_ASSERT: begin
            state_d = S_IDLE;
         end
         S_RET_MSTATUS: begin
            if (!csr_wb_we_i) state_d = S_RET_ASSERT;
         end
         S_RET_ASSERT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mepc_val_q <= '0;
         cause_q    <= '0;
      end else begin
         state_q    <= state_d;
         mepc_val_q <= mepc_val_d;
         cause_q    <= cause_d;
      end
   end

   // Output decode from the current state.
   always_comb begin
      we_raw     = 1'b0;
      waddr_raw  = '0;
      wdata_raw  = '0;
      assert_raw = 1'b0;
      iaddr_raw  = '0;
      case (state_q)
         S_WR_MEPC: begin
            we_raw    = 1'b1;
            waddr_raw = CSR_MEPC;
            wdata_raw = mepc_val_q;
         end
         S_WR_MSTATUS: begin
            // MPIE <= MIE, MIE <= 0
            we_raw    = 1'b1;
            waddr_raw = CSR_MSTATUS;
            wdata_raw = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                         csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
         end
         S_WR_MCAUSE: begin
            we_raw    = 1'b1;
            waddr_raw = CSR_MCAUSE;
            wdata_raw = cause_q;
         end
         S_ASSERT: begin
            assert_raw = 1'b1;
            iaddr_raw  = trap_vector;
         end
         S_RET_MSTATUS: begin
            // MIE <= MPIE, MPIE <= 1
            we_raw    = 1'b1;
            waddr_raw = CSR_MSTATUS;
            wdata_raw = {csr_mstatus_i[31:8], 1'b1,
                         csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
         end
         S_RET_ASSERT: begin
            assert_raw = 1'b1;
            iaddr_raw  = csr_mepc_i;
         end
         default: begin
         end
      endcase
   end

   // Outputs are forced to zero while reset is held, so a sequence that is
   // being aborted cannot issue its pending write or redirect.
   assign csr_we_o     = rst_n & we_raw & ~csr_wb_we_i;
   assign csr_waddr_o  = rst_n ? waddr_raw : '0;
   assign csr_wdata_o  = rst_n ? wdata_raw : '0;
   assign int_assert_o = rst_n & assert_raw;
   assign int_addr_o   = rst_n ? iaddr_raw : '0;
   assign hold_flag_o  = rst_n & ((state_q != S_IDLE) | accept);

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clint_trap_ctrl
//
// Reference model: every accepted trap expands into a list of pending
// actions (CSR writes, then one redirect). Each non-collision cycle retires
// the head action; the model derives the expected outputs from that list.
// Directed scenarios additionally pin exact cycles and literal values using
// a log of what the DUT actually committed.
// ---------------------------------------------------------------------------
module tb_clint_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_addr_i;
   logic        ecall_i, ebreak_i, mret_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic        hold_i;
   logic        timer_irq_i;
   logic        global_int_en_i;
   logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
   logic        csr_wb_we_i;
   logic        csr_we_o;
   logic [31:0] csr_waddr_o, csr_wdata_o;
   logic        hold_flag_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;

   clint_trap_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_addr_i     (inst_addr_i),
      .ecall_i         (ecall_i),
      .ebreak_i        (ebreak_i),
      .mret_i          (mret_i),
      .jump_i          (jump_i),
      .jump_addr_i     (jump_addr_i),
      .hold_i          (hold_i),
      .timer_irq_i     (timer_irq_i),
      .global_int_en_i (global_int_en_i),
      .csr_mtvec_i     (csr_mtvec_i),
      .csr_mepc_i      (csr_mepc_i),
      .csr_mstatus_i   (csr_mstatus_i),
      .csr_wb_we_i     (csr_wb_we_i),
      .csr_we_o        (csr_we_o),
      .csr_waddr_o     (csr_waddr_o),
      .csr_wdata_o     (csr_wdata_o),
      .hold_flag_o     (hold_flag_o),
      .int_assert_o    (int_assert_o),
      .int_addr_o      (int_addr_o)
   );

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   typedef enum int {A_MEPC, A_MST_TRAP, A_MCAUSE, A_VEC, A_MST_RET, A_RET} act_e;
   typedef struct {
      act_e        kind;
      logic [31:0] val;
   } act_t;
   act_t exp_q[$];

   typedef struct {
      int          cyc;
      bit          redir;
      logic [31:0] addr;
      logic [31:0] data;
   } obs_t;
   obs_t obs_q[$];
   bit   hold_seen[int];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void chk_word(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endfunction

   function automatic void chk_bit(string name, logic act, logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endfunction

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [31:0] trap_mstatus(logic [31:0] m);
      logic [31:0] r;
      r    = m;
      r[7] = m[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Trap return: MIE takes MPIE, MPIE is set.
   function automatic logic [31:0] ret_mstatus(logic [31:0] m);
      logic [31:0] r;
      r    = m;
      r[3] = m[7];
      r[7] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] vec_addr(logic [31:0] mtvec, logic [31:0] cause);
      logic [31:0] base;
      base = mtvec & 32'hFFFF_FFFC;
`ifdef CLINT_VECTORED_EN
      if (mtvec[1:0] == 2'b01 && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
`endif
      return base;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin : cmp
      logic        e_we, e_hold, e_as;
      logic [31:0] e_wa, e_wd, e_ia;
      logic [31:0] cause;
      act_t        a;
      e_we = 1'b0; e_hold = 1'b0; e_as = 1'b0;
      e_wa = '0;   e_wd = '0;     e_ia = '0;
      hold_seen[cyc] = hold_flag_o;
      if (!rst_n) begin
         exp_q.delete();
         chk_bit ("rst_we",     csr_we_o,     1'b0);
         chk_word("rst_waddr",  csr_waddr_o,  32'h0);
         chk_word("rst_wdata",  csr_wdata_o,  32'h0);
         chk_bit ("rst_hold",   hold_flag_o,  1'b0);
         chk_bit ("rst_assert", int_assert_o, 1'b0);
         chk_word("rst_iaddr",  int_addr_o,   32'h0);
      end else begin
         if (exp_q.size() == 0) begin
            if (ecall_i || ebreak_i) begin
               cause = ecall_i ? 32'd11 : 32'd3;
               exp_q.push_back('{A_MEPC, inst_addr_i});
               exp_q.push_back('{A_MST_TRAP, 32'h0});
               exp_q.push_back('{A_MCAUSE, cause});
               exp_q.push_back('{A_VEC, cause});
               e_hold = 1'b1;
            end else if (mret_i) begin
               exp_q.push_back('{A_MST_RET, 32'h0});
               exp_q.push_back('{A_RET, 32'h0});
               e_hold = 1'b1;
            end else if (timer_irq_i && global_int_en_i && !hold_i) begin
               exp_q.push_back('{A_MEPC, jump_i ? jump_addr_i : inst_addr_i});
               exp_q.push_back('{A_MST_TRAP, 32'h0});
               exp_q.push_back('{A_MCAUSE, 32'h8000_0007});
               exp_q.push_back('{A_VEC, 32'h8000_0007});
               e_hold = 1'b1;
            end
         end else begin
            e_hold = 1'b1;
            a = exp_q[0];
            case (a.kind)
               A_VEC: begin
                  e_as = 1'b1;
                  e_ia = vec_addr(csr_mtvec_i, a.val);
                  void'(exp_q.pop_front());
               end
               A_RET: begin
                  e_as = 1'b1;
                  e_ia = csr_mepc_i;
                  void'(exp_q.pop_front());
               end
               default: begin
                  if (!csr_wb_we_i) begin
                     e_we = 1'b1;
                     case (a.kind)
                        A_MEPC:     begin e_wa = 32'h341; e_wd = a.val; end
                        A_MST_TRAP: begin e_wa = 32'h300; e_wd = trap_mstatus(csr_mstatus_i); end
                        A_MCAUSE:   begin e_wa = 32'h342; e_wd = a.val; end
                        default:    begin e_wa = 32'h300; e_wd = ret_mstatus(csr_mstatus_i); end
                     endcase
                     void'(exp_q.pop_front());
                  end
               end
            endcase
         end
         chk_bit("we", csr_we_o, e_we);
         chk_bit("hold", hold_flag_o, e_hold);
         chk_bit("assert", int_assert_o, e_as);
         if (e_we) begin
            chk_word("waddr", csr_waddr_o, e_wa);
            chk_word("wdata", csr_wdata_o, e_wd);
         end
         if (e_as) chk_word("iaddr", int_addr_o, e_ia);
      end
      if (csr_we_o)     obs_q.push_back('{cyc, 1'b0, csr_waddr_o, csr_wdata_o});
      if (int_assert_o) obs_q.push_back('{cyc, 1'b1, int_addr_o, 32'h0});
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
      jump_i = 1'b0; hold_i = 1'b0; timer_irq_i = 1'b0;
      csr_wb_we_i = 1'b0;
   endtask

   task automatic expect_write(string name, int c, logic [31:0] addr, logic [31:0] data);
      int hits;
      hits = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].cyc == c && !obs_q[i].redir) begin
            hits++;
            chk_word({name, "_addr"}, obs_q[i].addr, addr);
            chk_word({name, "_data"}, obs_q[i].data, data);
         end
      end
      chk_word({name, "_count"}, hits, 32'd1);
   endtask

   task automatic expect_redirect(string name, int c, logic [31:0] addr);
      int hits;
      hits = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].cyc == c && obs_q[i].redir) begin
            hits++;
            chk_word({name, "_addr"}, obs_q[i].addr, addr);
         end
      end
      chk_word({name, "_count"}, hits, 32'd1);
   endtask

   function automatic int count_events(int lo, int hi);
      int n;
      n = 0;
      foreach (obs_q[i]) if (obs_q[i].cyc >= lo && obs_q[i].cyc <= hi) n++;
      return n;
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stim
      int t;
      int t0;
      quiet();
      rst_n           = 1'b0;
      inst_addr_i     = '0;
      jump_addr_i     = '0;
      global_int_en_i = 1'b0;
      csr_mtvec_i     = '0;
      csr_mepc_i      = '0;
      csr_mstatus_i   = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // ecall: three writes, redirect at T+4, hold T..T+4
      csr_mtvec_i   = 32'h8000_0100;
      csr_mstatus_i = 32'h0000_0008;
      inst_addr_i   = 32'h8000_0010;
      ecall_i       = 1'b1;
      t = cyc;
      tick();
      ecall_i = 1'b0;
      repeat (6) tick();
      expect_write("ecall_mepc",    t + 1, 32'h341, 32'h8000_0010);
      expect_write("ecall_mstatus", t + 2, 32'h300, 32'h0000_0080);
      expect_write("ecall_mcause",  t + 3, 32'h342, 32'd11);
      expect_redirect("ecall_vec",  t + 4, 32'h8000_0100);
      for (int k = 0; k <= 4; k++) chk_bit("ecall_hold", hold_seen[t + k], 1'b1);
      chk_bit("ecall_hold_end", hold_seen[t + 5], 1'b0);
      chk_word("ecall_events", count_events(t, t + 6), 32'd4);

      // mret: mstatus 0x80 -> 0x88, redirect to mepc at T+2
      csr_mstatus_i = 32'h0000_0080;
      csr_mepc_i    = 32'h8000_0014;
      mret_i        = 1'b1;
      t = cyc;
      tick();
      mret_i = 1'b0;
      repeat (4) tick();
      expect_write("mret_mstatus", t + 1, 32'h300, 32'h0000_0088);
      expect_redirect("mret_ret",  t + 2, 32'h8000_0014);

      // timer interrupt while EX is jumping: mepc takes the jump target
      csr_mstatus_i   = 32'h0000_0008;
      global_int_en_i = 1'b1;
      timer_irq_i     = 1'b1;
      jump_i          = 1'b1;
      jump_addr_i     = 32'h8000_0200;
      inst_addr_i     = 32'h8000_0030;
      t = cyc;
      tick();
      quiet();
      repeat (6) tick();
      expect_write("irq_mepc",   t + 1, 32'h341, 32'h8000_0200);
      expect_write("irq_mcause", t + 3, 32'h342, 32'h8000_0007);
      expect_redirect("irq_vec", t + 4, 32'h8000_0100);

      // interrupts globally disabled: nothing happens
      global_int_en_i = 1'b0;
      timer_irq_i     = 1'b1;
      t = cyc;
      repeat (5) tick();
      quiet();
      chk_word("irq_off_events", count_events(t, t + 4), 32'd0);
      chk_bit("irq_off_hold", hold_seen[t], 1'b0);

      // pending irq held off by hold_i for 5 cycles
      global_int_en_i = 1'b1;
      timer_irq_i     = 1'b1;
      hold_i          = 1'b1;
      inst_addr_i     = 32'h8000_0040;
      t0 = cyc;
      repeat (5) tick();
      hold_i = 1'b0;
      t = cyc;
      tick();
      quiet();
      repeat (6) tick();
      chk_word("held_events", count_events(t0, t0 + 4), 32'd0);
      chk_bit("held_hold", hold_seen[t0 + 2], 1'b0);
      expect_write("held_mepc",   t + 1, 32'h341, 32'h8000_0040);
      expect_write("held_mcause", t + 3, 32'h342, 32'h8000_0007);
      expect_redirect("held_vec", t + 4, 32'h8000_0100);

      // WB collision during WR_MSTATUS adds one cycle
      csr_mstatus_i = 32'h0000_0008;
      inst_addr_i   = 32'h8000_0050;
      ecall_i       = 1'b1;
      t = cyc;
      tick();
      ecall_i = 1'b0;
      tick();
      csr_wb_we_i = 1'b1;
      tick();
      csr_wb_we_i = 1'b0;
      repeat (5) tick();
      expect_write("coll_mepc",    t + 1, 32'h341, 32'h8000_0050);
      chk_word("coll_blocked", count_events(t + 2, t + 2), 32'd0);
      expect_write("coll_mstatus", t + 3, 32'h300, 32'h0000_0080);
      expect_write("coll_mcause",  t + 4, 32'h342, 32'd11);
      expect_redirect("coll_vec",  t + 5, 32'h8000_0100);

      // reset during WR_MCAUSE aborts the sequence
      inst_addr_i = 32'h8000_0060;
      ebreak_i    = 1'b1;
      t = cyc;
      tick();
      ebreak_i = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk_word("abort_events", count_events(t, t + 8), 32'd2);
      chk_bit("abort_hold_rst", hold_seen[t + 3], 1'b0);
      chk_bit("abort_hold_idle", hold_seen[t + 4], 1'b0);

      // vectored mtvec: only the vectored build offsets interrupts
      csr_mtvec_i     = 32'h8000_0101;
      global_int_en_i = 1'b1;
      timer_irq_i     = 1'b1;
      t = cyc;
      tick();
      quiet();
      repeat (6) tick();
`ifdef CLINT_VECTORED_EN
      expect_redirect("vec_irq", t + 4, 32'h8000_011C);
`else
      expect_redirect("vec_irq", t + 4, 32'h8000_0100);
`endif

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst_n           = ($urandom_range(0, 299) != 0);
         ecall_i         = ($urandom_range(0, 15) == 0);
         ebreak_i        = ($urandom_range(0, 15) == 0);
         mret_i          = ($urandom_range(0, 15) == 0);
         jump_i          = $urandom_range(0, 1) == 1;
         hold_i          = ($urandom_range(0, 3) == 0);
         timer_irq_i     = $urandom_range(0, 1) == 1;
         global_int_en_i = $urandom_range(0, 1) == 1;
         csr_wb_we_i     = ($urandom_range(0, 3) == 0);
         inst_addr_i     = $urandom & 32'hFFFF_FFFC;
         jump_addr_i     = $urandom & 32'hFFFF_FFFC;
         csr_mtvec_i     = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
         csr_mepc_i      = $urandom;
         csr_mstatus_i   = $urandom;
         tick();
      end
      quiet();
      rst_n = 1'b1;
      repeat (8) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clint_trap_ctrl.md
# clint_trap_ctrl

Core-local trap sequencer for the RV32 core. Detects synchronous traps (ecall, ebreak), mret and the machine timer interrupt, stalls the pipeline, and performs the required machine-CSR updates one write per cycle through the CSR file's clint write port. It then redirects fetch to the trap vector or to mepc. It sits beside EX and drives the CSR file's clint_we/waddr/wdata inputs.

## Interface
- No parameters. Data width is 32 bits. CSR numbers: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- inst_addr_i  in  32  PC of the instruction currently in EX
- ecall_i / ebreak_i / mret_i  in  1 each  decoded system instruction valid in EX this cycle
- jump_i  in  1  EX is taking a branch or jump this cycle
- jump_addr_i  in  32  target address for jump_i
- hold_i  in  1  EX is busy with a multi-cycle operation; asynchronous interrupts are not accepted
- timer_irq_i  in  1  level-sensitive machine timer interrupt
- global_int_en_i  in  1  mstatus.MIE from the CSR file
- csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  32 each  current CSR values from the CSR file
- csr_wb_we_i  in  1  WB is writing a CSR this cycle; WB has priority in the CSR file
- csr_we_o  out  1  CSR write strobe, to the clint write port
- csr_waddr_o  out  32  CSR address; bits [31:12] are always 0
- csr_wdata_o  out  32  CSR write data
- hold_flag_o  out  1  stall request for IF, ID and EX
- int_assert_o  out  1  one-cycle fetch redirect
- int_addr_o  out  32  redirect target, valid while int_assert_o=1

## Operation
- States: IDLE, WR_MEPC, WR_MSTATUS, WR_MCAUSE, ASSERT, RET_MSTATUS, RET_ASSERT.
- Acceptance in IDLE uses this priority order: ecall/ebreak, then mret, then interrupt.
- ecall or ebreak:
  - Latch mepc_val = inst_addr_i.
  - Latch cause = 11 for ecall, 3 for ebreak.
  - Go to WR_MEPC.
- mret: go to RET_MSTATUS.
- Interrupt:
  - Accepted when timer_irq_i & global_int_en_i & !hold_i and no system instruction is present.
  - Latch mepc_val = jump_i ? jump_addr_i : inst_addr_i.
  - Latch cause = 0x8000_0007.
  - Go to WR_MEPC.
- WR_MEPC: write mepc_val to 0x341, then go to WR_MSTATUS.
- WR_MSTATUS: write csr_mstatus_i with bit 7 (MPIE) set to old bit 3 and bit 3 (MIE) cleared to 0. Then go to WR_MCAUSE.
- WR_MCAUSE: write the latched cause to 0x342, then go to ASSERT.
- ASSERT: int_assert_o=1; int_addr_o = trap vector (see Configuration). Then go to IDLE.
- RET_MSTATUS: write csr_mstatus_i with bit 3 set to old bit 7 and bit 7 set to 1. Then go to RET_ASSERT.
- RET_ASSERT: int_assert_o=1; int_addr_o = csr_mepc_i. Then go to IDLE.
- WB collision: if csr_wb_we_i=1 in any write state, drive csr_we_o=0 and stay in that state. Retry the next cycle.
- hold_flag_o = 1 in every non-IDLE state, and in the IDLE cycle in which a trap is accepted. This output is combinational.
- csr_we_o=1 only in the WR_* and RET_MSTATUS states, and only when csr_wb_we_i=0.

## Timing
- Reset: state=IDLE. All outputs are 0. The latched mepc_val and cause are cleared to 0.
- Reset asserted mid-sequence aborts it. No further CSR writes occur.
- ecall or interrupt accepted in cycle T, with no collision:
  - mepc written at T+1, mstatus at T+2, mcause at T+3.
  - int_assert_o at T+4.
  - Fetch resumes at T+5.
- mret at T: mstatus written at T+1, int_assert_o at T+2.
- Each collision cycle adds exactly one cycle of latency.
- A timer interrupt that arrives while hold_i=1 stays pending, since the input is level-sensitive. It is taken in the first IDLE cycle with hold_i=0.
- System instructions and interrupts arriving in a non-IDLE state are ignored. The pipeline is held, so the instruction is re-presented.
- The CSR file forwards a same-address clint write on its read path. WR_MSTATUS therefore sees the committed value.

## Configuration
- CLINT_VECTORED_EN:
  - Defined: when csr_mtvec_i[1:0]==2'b01 and cause bit 31 is set, int_addr_o = {mtvec[31:2],2'b00} + 4*cause[30:0]. Synchronous traps use the base address.
  - Not defined: int_addr_o = {mtvec[31:2],2'b00} for all traps.

## Test plan
- ecall at PC 0x8000_0010, mtvec=0x8000_0100, mstatus=0x8:
  - Writes in order: mepc=0x8000_0010, mstatus=0x80, mcause=11.
  - int_assert_o with address 0x8000_0100 at T+4.
  - hold_flag_o=1 from T through T+4.
- mret with mstatus=0x80, mepc=0x8000_0014: mstatus written to 0x88; redirect to 0x8000_0014 at T+2.
- Timer interrupt with jump_i=1, jump_addr_i=0x8000_0200: mepc=0x8000_0200 and mcause=0x8000_0007. Repeat with global_int_en_i=0 -> no action.
- timer_irq_i held high while hold_i=1 for 5 cycles: no acceptance until hold_i drops; the sequence then completes normally.
- csr_wb_we_i pulsed during WR_MSTATUS: csr_we_o=0 that cycle; mstatus is written one cycle later and int_assert_o arrives at T+5.
- rst_n low during WR_MCAUSE: no mcause write; int_assert_o stays 0; the block returns to IDLE. With CLINT_VECTORED_EN and mtvec=0x8000_0101, a timer interrupt redirects to 0x8000_011C.
